// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, FSM state and constant definitions for the ALU request scheduler.
// Also holds a small helper that tells the multi-cycle ops apart from the single-cycle ones.
package alu_ctrl_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Wide enough for any RW; users slice off the low RW bits.
  localparam logic [31:0] DIV0_RESULT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  // mul and div iterate W cycles; add and sub finish in one.
  function automatic logic is_iter(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_req_scheduler_if.sv
// Request/response bundle between the two requesters, the scheduler and the result consumer.
// The master side drives requests and rsp_ready; the slave (scheduler) side answers.
interface alu_req_scheduler_if #(
  parameter int W  = 3,
  parameter int RW = 2 * W
) ();

  logic          req0_valid;
  logic          req0_ready;
  logic [1:0]    req0_op;
  logic [W-1:0]  req0_a;
  logic [W-1:0]  req0_b;

  logic          req1_valid;
  logic          req1_ready;
  logic [1:0]    req1_op;
  logic [W-1:0]  req1_a;
  logic [W-1:0]  req1_b;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [RW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/alu_iter_core.sv
// Iterative add/sub/mul/div datapath: start loads operands, each step advances one iteration.
// result/err are meaningful on the step where done is high, so the caller can register them directly.
module alu_iter_core
  import alu_ctrl_pkg::*;
#(
  parameter int W  = 3,
  parameter int RW = 2 * W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  input  logic [1:0]    op,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          done,
  output logic [RW-1:0] result,
  output logic          err
);

  localparam int CW = $clog2(W + 1);

  logic [1:0]    op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [RW-1:0] mcand_q;
  logic [RW-1:0] acc_q;
  logic [W-1:0]  rem_q;
  logic [CW-1:0] cnt_q;

  logic [RW-1:0] acc_next;
  logic [W-1:0]  rem_next;
  logic [W:0]    trial;
  logic          qbit;

  // mul: shift-add over b LSB first; div: restoring division over a MSB first.
  always_comb begin
    acc_next = acc_q;
    rem_next = rem_q;
    trial    = {rem_q, a_q[W-1]};
    qbit     = 1'b0;
    result   = acc_q;
    err      = 1'b0;
    unique case (op_q)
      OP_ADD: result = RW'(a_q) + RW'(b_q);
      OP_SUB: result = RW'(a_q) - RW'(b_q);
      OP_MUL: begin
        acc_next = acc_q + (b_q[0] ? mcand_q : '0);
        result   = acc_next;
      end
      OP_DIV: begin
        qbit     = (trial >= {1'b0, b_q});
        rem_next = qbit ? W'(trial - {1'b0, b_q}) : trial[W-1:0];
        acc_next = {acc_q[RW-2:0], qbit};
        err      = (b_q == '0);
        result   = err ? DIV0_RESULT[RW-1:0] : acc_next;
      end
      default: result = acc_q;
    endcase
  end

  assign done = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      op_q    <= op;
      a_q     <= a;
      b_q     <= b;
      mcand_q <= RW'(a);
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= is_iter(op) ? CW'(W) : CW'(1);
    end else if (step) begin
      acc_q   <= acc_next;
      rem_q   <= rem_next;
      mcand_q <= mcand_q << 1;
      cnt_q   <= cnt_q - CW'(1);
      if (op_q == OP_MUL) b_q <= b_q >> 1;
      if (op_q == OP_DIV) a_q <= a_q << 1;
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one iterative ALU between two requesters.
// Owns arbitration, the IDLE/EXEC/RESP sequencing and the registered response channel.
module alu_req_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int W  = 3,
  parameter int RW = 2 * W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  alu_req_scheduler_if.slave bus
);

  state_t        state;
  logic          last_grant;
  logic          owner_id;
  logic          any_req;
  logic          grant_id;
  logic          handshake;
  logic [1:0]    sel_op;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;

  logic          core_step;
  logic          core_done;
  logic          core_err;
  logic [RW-1:0] core_result;

  logic          rsp_valid_q;
  logic          rsp_id_q;
  logic          rsp_err_q;
  logic [RW-1:0] rsp_data_q;

  // With both requesters asking, the one served less recently wins.
  always_comb begin
    any_req   = bus.req0_valid | bus.req1_valid;
    grant_id  = (bus.req0_valid && bus.req1_valid) ? ~last_grant : ~bus.req0_valid;
    handshake = (state == IDLE) && ena && any_req;
    sel_op    = grant_id ? bus.req1_op : bus.req0_op;
    sel_a     = grant_id ? bus.req1_a  : bus.req0_a;
    sel_b     = grant_id ? bus.req1_b  : bus.req0_b;
  end

  assign bus.req0_ready = handshake & ~grant_id;
  assign bus.req1_ready = handshake &  grant_id;
  assign core_step      = (state == EXEC) && ena;

  alu_iter_core #(.W(W), .RW(RW)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (handshake),
    .step   (core_step),
    .op     (sel_op),
    .a      (sel_a),
    .b      (sel_b),
    .done   (core_done),
    .result (core_result),
    .err    (core_err)
  );

  // Everything freezes while ena is low, including a pending response transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner_id    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= grant_id;
            owner_id   <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (core_done) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= core_result;
            rsp_err_q   <= core_err;
            rsp_id_q    <= owner_id;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed plus randomized checks of alu_req_scheduler against an arithmetic/round-robin reference model.
module tb_alu_req_scheduler;
  import alu_ctrl_pkg::*;

  localparam int W  = 3;
  localparam int RW = 2 * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;

  alu_req_scheduler_if #(.W(W)) bus ();

  alu_req_scheduler #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  bit model_last = 1'b1;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [RW-1:0] model_result(input logic [1:0] op, input int a, input int b);
    case (op)
      2'd0:    return RW'(a + b);
      2'd1:    return RW'(a - b);
      2'd2:    return RW'(a * b);
      default: return (b == 0) ? RW'(63) : RW'(a / b);
    endcase
  endfunction

  task automatic apply_stimulus(input logic v0, input logic [1:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                                input logic v1, input logic [1:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
  endtask

  task automatic apply_noise(input logic v);
    apply_stimulus(v, 2'($urandom_range(0, 3)), W'($urandom_range(0, 7)), W'($urandom_range(0, 7)),
                   v, 2'($urandom_range(0, 3)), W'($urandom_range(0, 7)), W'($urandom_range(0, 7)));
  endtask

  task automatic run_txn(input string name,
                         input bit v0, input logic [1:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input bit v1, input logic [1:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input int stall, input int gap);
    bit gid;
    logic [1:0] op;
    int a, b, lat, exp_lat;
    logic [RW-1:0] exp_data;
    bit exp_err, got;
    gid      = (v0 && v1) ? !model_last : !v0;
    op       = gid ? op1 : op0;
    a        = gid ? int'(a1) : int'(a0);
    b        = gid ? int'(b1) : int'(b0);
    exp_data = model_result(op, a, b);
    exp_err  = (op == 2'd3) && (b == 0);
    exp_lat  = (op >= 2'd2) ? (W + gap) : 1;

    @(negedge clk);
    ena = 1'b1;
    bus.rsp_ready = 1'b0;
    apply_stimulus(v0, op0, a0, b0, v1, op1, a1, b1);
    #1;
    check_output({name, " ready0"}, bus.req0_ready, v0 && !gid);
    check_output({name, " ready1"}, bus.req1_ready, v1 && gid);
    @(posedge clk);
    model_last = gid;
    @(negedge clk);
    apply_noise(1'b0);

    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (k > 1) @(negedge clk);
      ena = !(k >= 2 && k < 2 + gap);
      @(posedge clk);
      #1;
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        lat = k;
      end
    end
    check_output({name, " latency"}, lat, exp_lat);
    check_output({name, " data"}, bus.rsp_data, exp_data);
    check_output({name, " id"}, bus.rsp_id, gid);
    check_output({name, " err"}, bus.rsp_err, exp_err);
    check_output({name, " busy"}, bus.busy, 1'b1);

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      ena = 1'b1;
      apply_noise(1'b1);
      #1;
      check_output({name, " stall ready"}, {bus.req0_ready, bus.req1_ready}, 2'b00);
      @(posedge clk);
      #1;
      check_output({name, " stall hold"}, {bus.rsp_valid, bus.busy, bus.rsp_data}, {2'b11, exp_data});
    end

    @(negedge clk);
    ena = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    check_output({name, " xfer ready"}, {bus.req0_ready, bus.req1_ready}, 2'b00);
    @(posedge clk);
    #1;
    check_output({name, " after xfer"}, {bus.rsp_valid, bus.busy}, 2'b00);
    @(negedge clk);
    apply_noise(1'b0);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit v0, v1;
    apply_stimulus(0, 2'd0, '0, '0, 0, 2'd0, '0, '0);
    bus.rsp_ready = 1'b0;
    #3;
    check_output("reset outputs", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.busy, bus.rsp_data}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;

    run_txn("add 3+4",    1, OP_ADD, 3, 4, 0, OP_ADD, 0, 0, 0, 0);
    run_txn("mul 7*7",    0, OP_ADD, 0, 0, 1, OP_MUL, 7, 7, 0, 0);
    run_txn("div 6/4",    0, OP_ADD, 0, 0, 1, OP_DIV, 6, 4, 0, 0);
    run_txn("sub 2-5",    0, OP_ADD, 0, 0, 1, OP_SUB, 2, 5, 0, 0);
    run_txn("div 5/0",    1, OP_DIV, 5, 0, 0, OP_ADD, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      run_txn("round robin", 1, OP_ADD, 1, W'(i), 1, OP_SUB, 7, W'(i), 0, 0);
    run_txn("backpressure", 1, OP_ADD, 2, 2, 0, OP_ADD, 0, 0, 5, 0);
    run_txn("ena gap mul",  0, OP_ADD, 0, 0, 1, OP_MUL, 5, 6, 0, 4);

    @(negedge clk);
    ena = 1'b1;
    apply_stimulus(0, OP_ADD, 0, 0, 1, OP_MUL, 7, 7);
    @(posedge clk);
    @(negedge clk);
    apply_noise(1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async reset", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.busy, bus.rsp_data}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_output("no rsp after reset", {bus.rsp_valid, bus.busy}, 2'b00);
    end
    bus.rsp_ready = 1'b0;
    run_txn("first grant", 1, OP_ADD, 1, 1, 1, OP_ADD, 6, 6, 0, 0);

    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      run_txn("random", v0, 2'($urandom_range(0, 3)), W'($urandom_range(0, 7)), W'($urandom_range(0, 7)),
              v1, 2'($urandom_range(0, 3)), W'($urandom_range(0, 7)), W'($urandom_range(0, 7)),
              $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
